// File: rtl/arbitro_registrador_pkg.sv
// Shared definitions for the registrador write arbiter: FSM encodings,
// default word width and the modulo-N index helper used by the selector.
package arbitro_registrador_pkg;

   localparam int DEF_BITS = 63;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ESCRITA = 2'd1;
   localparam logic [1:0] ST_ACK     = 2'd2;

   // (a + b) mod n for 0 <= a, b < n, without a divider
   function automatic int wrap_add(input int a, input int b, input int n);
      int s;
      s = a + b;
      if (s >= n) s = s - n;
      return s;
   endfunction

endpackage

// File: rtl/arbitro_registrador_seletor_rr.sv
// Round-robin search: rotate req so ptr sits at bit 0, take the lowest set
// bit, then rotate the offset back into a requester index.
module seletor_rr
   import arbitro_registrador_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int PTR_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic             found,
   output logic [PTR_W-1:0] idx
);

   logic [N_REQ-1:0] rot;
   logic [PTR_W-1:0] off;

   always_comb begin
      rot = '0;
      for (int j = 0; j < N_REQ; j++)
         rot[j] = req[wrap_add(int'(ptr), j, N_REQ)];
   end

   always_comb begin
      off = '0;
      for (int j = N_REQ - 1; j >= 0; j--)
         if (rot[j]) off = PTR_W'(j);
   end

   assign found = |rot;
   assign idx   = PTR_W'(wrap_add(int'(ptr), int'(off), N_REQ));

endmodule

// File: rtl/arbitro_registrador.sv
// Round-robin write arbiter in front of a shared registrador: one grant,
// one load pulse and one ack per transaction, three cycles each.
module arbitro_registrador
   import arbitro_registrador_pkg::*;
#(
   parameter int BITS  = DEF_BITS,
   parameter int N_REQ = 4,
   parameter int PTR_W = 2
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ*(BITS+1)-1:0]  data_req,
   output logic [N_REQ-1:0]           ack,
   output logic                       reg_load,
   output logic [BITS:0]              reg_data,
   output logic                       busy,
   output logic [PTR_W-1:0]           grant_idx
);

   localparam int W = BITS + 1;

   logic [1:0]       state_q, state_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [PTR_W-1:0] gidx_q, gidx_d;
   logic [BITS:0]    cap_q, cap_d;

   logic             found;
   logic [PTR_W-1:0] win_idx;

   seletor_rr #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_sel (
      .req   (req),
      .ptr   (ptr_q),
      .found (found),
      .idx   (win_idx)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gidx_d  = gidx_q;
      cap_d   = cap_q;
      case (state_q)
         ST_IDLE: begin
            if (found) begin
               gidx_d = win_idx;
               for (int i = 0; i < N_REQ; i++)
                  if (win_idx == PTR_W'(i)) cap_d = data_req[i*W +: W];
               state_d = ST_ESCRITA;
            end
         end
         ST_ESCRITA: state_d = ST_ACK;
         ST_ACK: begin
            // Winner drops to lowest priority; explicit wrap keeps
            // non-power-of-two N_REQ from ever producing idx >= N_REQ
            if (gidx_q == PTR_W'(N_REQ - 1)) ptr_d = '0;
            else                             ptr_d = gidx_q + PTR_W'(1);
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         gidx_q  <= '0;
         cap_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gidx_q  <= gidx_d;
         cap_q   <= cap_d;
      end
   end

   // Gated by reset_n so an aborted transaction never loads or acks at the reset edge
   always_comb begin
      ack = '0;
      for (int i = 0; i < N_REQ; i++)
         ack[i] = reset_n && (state_q == ST_ACK) && (gidx_q == PTR_W'(i));
   end

   assign reg_load  = reset_n && (state_q == ST_ESCRITA);
   assign reg_data  = cap_q;
   assign busy      = (state_q == ST_ESCRITA) || (state_q == ST_ACK);
   assign grant_idx = gidx_q;

endmodule

// File: doc/arbitro_registrador.md
Name: arbitro_registrador

Overview:
- Round-robin write arbiter that shares one 64-bit registrador between N_REQ requesters.
- Accepts requests with per-requester data and serialises them into single-cycle load pulses on the shared register.
- Returns a one-cycle ack to the winning requester once the register has captured its data.
- Sits between the datapath units and the registrador instance; it is the only driver of that register's load/dataIn.

Parameters:
- BITS, 63, MSB index of the data word (word width BITS+1), same convention as registrador.
- N_REQ, 4, number of requesters (2..8).
- PTR_W, 2, width of the grant index; must satisfy 2**PTR_W >= N_REQ.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- req  input  N_REQ  request vector, bit i = requester i.
- data_req  input  N_REQ*(BITS+1)  packed request data; requester i occupies bits [i*(BITS+1) +: BITS+1].
- ack  output  N_REQ  one-hot, one-cycle completion pulse.
- reg_load  output  1  to registrador.load.
- reg_data  output  BITS+1  to registrador.dataIn.
- busy  output  1  high while a transaction is in flight (states ESCRITA, ACK).
- grant_idx  output  PTR_W  index of the current or last winner.

Behaviour:
- Reset: sampled on posedge clk while reset_n=0. Sets state=IDLE, ptr=0, grant_idx=0, captured data=0, ack=0, reg_load=0, busy=0. reg_data then shows 0.
- Reset mid-transaction: reset has priority over every transition. An aborted transaction produces no reg_load and no ack.
- FSM states: IDLE, ESCRITA, ACK, all registered.
- IDLE:
  - If req != 0: pick the first set bit searching upward from ptr, wrapping modulo N_REQ.
  - Latch the winner into grant_idx and its data slice into the capture register, then go to ESCRITA.
  - If req == 0: stay in IDLE.
- ESCRITA: reg_load=1 for exactly this cycle and reg_data=captured word. Go to ACK.
- ACK: ack[grant_idx]=1 for exactly this cycle and ptr <= (grant_idx+1) mod N_REQ. Go to IDLE. req is ignored in this state.
- Latency:
  - req sampled at edge k.
  - reg_load high in cycle k+1.
  - registrador updates at edge k+2.
  - ack high in cycle k+2.
  - Register value visible in the same cycle as ack.
- Throughput: one write per 3 cycles maximum.
- Requester rules:
  - Hold req and data until ack.
  - Drop req in the cycle after ack; if req stays high, the requester re-enters arbitration at the lowest priority.
  - Data is captured at the grant edge, so later data changes do not affect the write.
  - Dropping req after grant does not cancel the write; ack is still issued.
- Fairness: the ptr update guarantees each persistently requesting unit is served within N_REQ transactions.
- Simultaneous requests: resolved solely by ptr order; there is no fixed priority.
- Outputs:
  - reg_data is held stable outside ESCRITA; it keeps showing the captured word.
  - reg_load and ack are never high in the same cycle.
  - ack is at most one-hot.
- ptr wrap: after grant N_REQ-1, ptr=0. Non-power-of-two N_REQ must never produce an index >= N_REQ.

Decomposition:
- Shared header file (arbitro_defs.vh) holds:
  - state encodings: IDLE=2'd0, ESCRITA=2'd1, ACK=2'd2; 2'd3 is illegal and recovers to IDLE.
  - the default word width.
- Sub-module seletor_rr: combinational, inputs req and ptr, outputs found and idx.
  - Implemented as a rotate, priority-encode, rotate-back search.
  - Unit-testable in isolation.
- The top module holds the FSM, ptr, capture register and output decode.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with req=4'b1111 -> ack=0, reg_load=0, busy=0, grant_idx=0. After release, the first grant is to requester 0.
- Single request: req=4'b0100, data2=64'hDEADBEEF00000001 -> reg_load pulses in cycle k+1 with reg_data=64'hDEADBEEF00000001. ack=4'b0100 in cycle k+2. Register reads 64'hDEADBEEF00000001 in cycle k+2.
- Round robin: req=4'b1111 held, each requester dropping req after its own ack -> ack order 0,1,2,3. ptr wraps to 0. Exactly 4 reg_load pulses, 3 cycles apart.
- Fairness/wrap: ptr=3, req=4'b1001 -> requester 3 served first, then requester 0.
- Early drop: req=4'b0010 is granted, then req drops during ESCRITA -> the write still occurs and ack=4'b0010 is still pulsed.
- Reset mid-transaction: assert reset_n=0 during ESCRITA -> the register keeps its old value on the next edge (load was 0 at that edge), no ack is issued, and the FSM returns to IDLE with ptr=0.
